// File: rtl/misc_pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller: FSM states,
// operand forward-select codes, and the bundle of pipeline-register controls.
package misc_pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_ABORT   = 2'd2
    } state_t;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REGFILE = 2'b00;
    localparam fwd_sel_t FWD_MEM     = 2'b10;
    localparam fwd_sel_t FWD_WB      = 2'b01;

    localparam int DEFAULT_MEM_TIMEOUT = 255;
    localparam int WAIT_CNT_W          = 8;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_write;
        logic exmem_write;
        logic memwb_write;
        logic ifid_flush;
        logic idex_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_RESET  = 7'b0000011;
    localparam pipe_ctrl_t CTRL_FREEZE = 7'b0000000;
    localparam pipe_ctrl_t CTRL_NORMAL = 7'b1111100;

endpackage

// File: rtl/fwd_unit.sv
// EX operand forward select: the newer MEM result wins over WB; register 0
// is hard-wired and never forwarded.
module fwd_unit
    import misc_pipe_pkg::*;
#(
    parameter int REG_W = 4
) (
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_reg_write,
    output fwd_sel_t         sel
);

    always_comb begin
        sel = FWD_REGFILE;
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs)) begin
            sel = FWD_MEM;
        end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: memory-wait stall with timeout abort,
// branch flush, load-use interlock, operand forwarding and a stall counter.
module pipeline_hazard_ctrl
    import misc_pipe_pkg::*;
#(
    parameter int REG_W       = 4,
    parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [REG_W-1:0] IDRs1,
    input  logic [REG_W-1:0] IDRs2,
    input  logic             IDUsesRs1,
    input  logic             IDUsesRs2,
    input  logic [REG_W-1:0] EXRs1,
    input  logic [REG_W-1:0] EXRs2,
    input  logic [REG_W-1:0] EXRd,
    input  logic             EXMemRead,
    input  logic             BranchTaken,
    input  logic [REG_W-1:0] MEMRd,
    input  logic             MEMRegWrite,
    input  logic             MemReq,
    input  logic             MemReady,
    input  logic [REG_W-1:0] WBRd,
    input  logic             WBRegWrite,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEXWrite,
    output logic             EXMEMWrite,
    output logic             MEMWBWrite,
    output logic             IFIDFlush,
    output logic             IDEXFlush,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic             MemErr,
    output logic [15:0]      StallCycles
);

    state_t                state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  mem_err_q;
    logic [15:0]           stall_q;

    pipe_ctrl_t ctrl;
    logic       mem_stall;
    logic       load_use;
    logic       timeout_hit;
    fwd_sel_t   fwd_a;
    fwd_sel_t   fwd_b;

    // NOTE: every signal assigned in always_comb gets a default first so no path infers a latch.
    always_comb begin
        mem_stall = ((state == ST_RUN) && MemReq && !MemReady) ||
                    ((state == ST_MEMWAIT) && !MemReady);
        load_use  = EXMemRead && (EXRd != '0) &&
                    ((IDUsesRs1 && (IDRs1 == EXRd)) || (IDUsesRs2 && (IDRs2 == EXRd)));
        timeout_hit = (state == ST_MEMWAIT) && !MemReady &&
                      (({1'b0, wait_cnt} + 9'd1) >= 9'(MEM_TIMEOUT));

        ctrl = CTRL_NORMAL;
        if (Reset) begin
            ctrl = CTRL_RESET;
        end else if (mem_stall) begin
            ctrl = CTRL_FREEZE;
        end else if (state == ST_ABORT) begin
            ctrl.memwb_write = 1'b0;
        end else if (BranchTaken) begin
            // Reached in RUN or in the MEMWAIT release cycle; EX was held, so a deferred branch lands here.
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
        end else if ((state == ST_RUN) && load_use) begin
            ctrl.pc_write   = 1'b0;
            ctrl.ifid_write = 1'b0;
            ctrl.idex_flush = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            mem_err_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            if (!ctrl.pc_write && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
            unique case (state)
                ST_RUN: begin
                    if (MemReq && !MemReady) begin
                        state    <= ST_MEMWAIT;
                        wait_cnt <= '0;
                    end
                end
                ST_MEMWAIT: begin
                    if (MemReady) begin
                        state <= ST_RUN;
                    end else if (timeout_hit) begin
                        state     <= ST_ABORT;
                        mem_err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_ABORT: state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
        end
    end

    fwd_unit #(.REG_W(REG_W)) u_fwd_a (
        .rs            (EXRs1),
        .mem_rd        (MEMRd),
        .mem_reg_write (MEMRegWrite),
        .wb_rd         (WBRd),
        .wb_reg_write  (WBRegWrite),
        .sel           (fwd_a)
    );

    fwd_unit #(.REG_W(REG_W)) u_fwd_b (
        .rs            (EXRs2),
        .mem_rd        (MEMRd),
        .mem_reg_write (MEMRegWrite),
        .wb_rd         (WBRd),
        .wb_reg_write  (WBRegWrite),
        .sel           (fwd_b)
    );

    assign PCWrite     = ctrl.pc_write;
    assign IFIDWrite   = ctrl.ifid_write;
    assign IDEXWrite   = ctrl.idex_write;
    assign EXMEMWrite  = ctrl.exmem_write;
    assign MEMWBWrite  = ctrl.memwb_write;
    assign IFIDFlush   = ctrl.ifid_flush;
    assign IDEXFlush   = ctrl.idex_flush;
    assign ForwardA    = Reset ? FWD_REGFILE : fwd_a;
    assign ForwardB    = Reset ? FWD_REGFILE : fwd_b;
    // Status outputs read as cleared for the whole time Reset is held, not only after the edge.
    assign MemErr      = mem_err_q & ~Reset;
    assign StallCycles = Reset ? 16'd0 : stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed bench for pipeline_hazard_ctrl: two instances (default
// and short memory timeout) share stimulus and are compared with a behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int REG_W = 4;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic             Reset;
    logic [REG_W-1:0] IDRs1, IDRs2, EXRs1, EXRs2, EXRd, MEMRd, WBRd;
    logic             IDUsesRs1, IDUsesRs2, EXMemRead, BranchTaken;
    logic             MEMRegWrite, MemReq, MemReady, WBRegWrite;

    logic [1:0]  pcw, ifidw, idexw, exmemw, memwbw, iffl, idfl, merr;
    logic [1:0]  fa [2];
    logic [1:0]  fb [2];
    logic [15:0] stc [2];

    pipeline_hazard_ctrl #(.REG_W(REG_W)) dut (
        .CLK(CLK), .Reset(Reset),
        .IDRs1(IDRs1), .IDRs2(IDRs2), .IDUsesRs1(IDUsesRs1), .IDUsesRs2(IDUsesRs2),
        .EXRs1(EXRs1), .EXRs2(EXRs2), .EXRd(EXRd), .EXMemRead(EXMemRead),
        .BranchTaken(BranchTaken), .MEMRd(MEMRd), .MEMRegWrite(MEMRegWrite),
        .MemReq(MemReq), .MemReady(MemReady), .WBRd(WBRd), .WBRegWrite(WBRegWrite),
        .PCWrite(pcw[0]), .IFIDWrite(ifidw[0]), .IDEXWrite(idexw[0]),
        .EXMEMWrite(exmemw[0]), .MEMWBWrite(memwbw[0]),
        .IFIDFlush(iffl[0]), .IDEXFlush(idfl[0]),
        .ForwardA(fa[0]), .ForwardB(fb[0]), .MemErr(merr[0]), .StallCycles(stc[0])
    );

    pipeline_hazard_ctrl #(.REG_W(REG_W), .MEM_TIMEOUT(3)) dut_to (
        .CLK(CLK), .Reset(Reset),
        .IDRs1(IDRs1), .IDRs2(IDRs2), .IDUsesRs1(IDUsesRs1), .IDUsesRs2(IDUsesRs2),
        .EXRs1(EXRs1), .EXRs2(EXRs2), .EXRd(EXRd), .EXMemRead(EXMemRead),
        .BranchTaken(BranchTaken), .MEMRd(MEMRd), .MEMRegWrite(MEMRegWrite),
        .MemReq(MemReq), .MemReady(MemReady), .WBRd(WBRd), .WBRegWrite(WBRegWrite),
        .PCWrite(pcw[1]), .IFIDWrite(ifidw[1]), .IDEXWrite(idexw[1]),
        .EXMEMWrite(exmemw[1]), .MEMWBWrite(memwbw[1]),
        .IFIDFlush(iffl[1]), .IDEXFlush(idfl[1]),
        .ForwardA(fa[1]), .ForwardB(fb[1]), .MemErr(merr[1]), .StallCycles(stc[1])
    );

    // Behavioural model: one entry per instance; cycle-level bookkeeping of the memory wait.
    int tmo [2] = '{255, 3};
    bit m_wait [2]   = '{0, 0};
    int m_waited [2] = '{0, 0};
    bit m_abort [2]  = '{0, 0};
    bit m_err [2]    = '{0, 0};
    int m_stalls [2] = '{0, 0};

    int n_checks = 0;
    int n_fail   = 0;
    bit do_check = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bit order {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite, IFIDFlush, IDEXFlush}.
    function automatic logic [6:0] got_ctrl(int k);
        return {pcw[k], ifidw[k], idexw[k], exmemw[k], memwbw[k], iffl[k], idfl[k]};
    endfunction

    function automatic logic [6:0] exp_ctrl(int k);
        bit running, stall, lu;
        running = !m_wait[k] && !m_abort[k];
        stall   = !MemReady && (m_wait[k] || (running && MemReq));
        lu      = EXMemRead && (EXRd != 0) &&
                  ((IDUsesRs1 && IDRs1 == EXRd) || (IDUsesRs2 && IDRs2 == EXRd));
        if (Reset)               return 7'b0000011;
        if (stall)               return 7'b0000000;
        if (m_abort[k])          return 7'b1111000;
        if (BranchTaken)         return 7'b1111111;
        if (running && lu)       return 7'b0011101;
        return 7'b1111100;
    endfunction

    function automatic logic [1:0] exp_fwd(logic [REG_W-1:0] rs);
        if (Reset) return 2'b00;
        if (MEMRegWrite && MEMRd != 0 && MEMRd == rs) return 2'b10;
        if (WBRegWrite && WBRd != 0 && WBRd == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_update(int k);
        logic [6:0] e;
        e = exp_ctrl(k);
        if (Reset) begin
            m_wait[k] = 0; m_waited[k] = 0; m_abort[k] = 0; m_err[k] = 0; m_stalls[k] = 0;
        end else begin
            if (!e[6] && m_stalls[k] < 65535) m_stalls[k]++;
            if (m_abort[k]) begin
                m_abort[k] = 0;
            end else if (m_wait[k]) begin
                if (MemReady) begin
                    m_wait[k] = 0;
                end else if (m_waited[k] + 1 >= tmo[k]) begin
                    m_wait[k] = 0; m_abort[k] = 1; m_err[k] = 1;
                end else begin
                    m_waited[k]++;
                end
            end else if (MemReq && !MemReady) begin
                m_wait[k] = 1; m_waited[k] = 0;
            end
        end
    endtask

    task automatic eval();
        #1;
        if (do_check) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("ctrl%0d", k), 32'(got_ctrl(k)), 32'(exp_ctrl(k)));
                check($sformatf("fwdA%0d", k), 32'(fa[k]), 32'(exp_fwd(EXRs1)));
                check($sformatf("fwdB%0d", k), 32'(fb[k]), 32'(exp_fwd(EXRs2)));
                check($sformatf("memerr%0d", k), 32'(merr[k]), Reset ? 32'd0 : 32'(m_err[k]));
                check($sformatf("stalls%0d", k), 32'(stc[k]), Reset ? 32'd0 : 32'(m_stalls[k]));
            end
        end
    endtask

    task automatic adv();
        for (int k = 0; k < 2; k++) model_update(k);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        Reset = 0; IDRs1 = 0; IDRs2 = 0; IDUsesRs1 = 0; IDUsesRs2 = 0;
        EXRs1 = 0; EXRs2 = 0; EXRd = 0; EXMemRead = 0; BranchTaken = 0;
        MEMRd = 0; MEMRegWrite = 0; MemReq = 0; MemReady = 0; WBRd = 0; WBRegWrite = 0;
    endtask

    task automatic reset_cycle();
        idle();
        Reset = 1;
        eval();
        adv();
        Reset = 0;
    endtask

    task automatic randomize_inputs();
        IDRs1 = 4'($urandom_range(0, 7));  IDRs2 = 4'($urandom_range(0, 7));
        EXRs1 = 4'($urandom_range(0, 7));  EXRs2 = 4'($urandom_range(0, 7));
        EXRd  = 4'($urandom_range(0, 7));  MEMRd = 4'($urandom_range(0, 7));
        WBRd  = 4'($urandom_range(0, 7));
        IDUsesRs1   = 1'($urandom % 2);    IDUsesRs2  = 1'($urandom % 2);
        MEMRegWrite = 1'($urandom % 2);    WBRegWrite = 1'($urandom % 2);
        EXMemRead   = ($urandom % 3) == 0;
        BranchTaken = ($urandom % 6) == 0;
        MemReq      = ($urandom % 3) == 0;
        MemReady    = ($urandom % 10) < 6;
        Reset       = ($urandom % 100) == 0;
    endtask

    initial begin
        idle();
        Reset = 1;
        @(posedge CLK);
        #1;
        do_check = 1'b1;

        // Reset state, with forwarding inputs that would otherwise match.
        EXRs1 = 5; MEMRd = 5; MEMRegWrite = 1;
        eval();
        check("rst_ctrl", 32'(got_ctrl(0)), 32'h03);
        check("rst_fwdA", 32'(fa[0]), 32'd0);
        check("rst_stalls", 32'(stc[0]), 32'd0);
        check("rst_memerr", 32'(merr[0]), 32'd0);
        adv();

        // Load-use: one interlock cycle, one stall counted.
        idle();
        EXMemRead = 1; EXRd = 3; IDRs1 = 3; IDUsesRs1 = 1;
        eval();
        check("lu_ctrl", 32'(got_ctrl(0)), 32'h1D);
        adv();
        idle();
        eval();
        check("lu_stalls", 32'(stc[0]), 32'd1);
        adv();

        // Branch beats load-use.
        EXMemRead = 1; EXRd = 3; IDRs1 = 3; IDUsesRs1 = 1; BranchTaken = 1;
        eval();
        check("br_lu_ctrl", 32'(got_ctrl(0)), 32'h7F);
        adv();

        // Four memory-wait cycles then release; short-timeout instance aborts instead.
        reset_cycle();
        idle();
        MemReq = 1;
        for (int i = 0; i < 4; i++) begin
            eval();
            check("mw_ctrl", 32'(got_ctrl(0)), 32'h00);
            check("to_wait_ctrl", 32'(got_ctrl(1)), 32'h00);
            adv();
        end
        MemReady = 1;
        eval();
        check("mw_release", 32'(got_ctrl(0)), 32'h7C);
        check("to_abort_ctrl", 32'(got_ctrl(1)), 32'h78);
        check("to_abort_err", 32'(merr[1]), 32'd1);
        adv();
        idle();
        eval();
        check("mw_stalls", 32'(stc[0]), 32'd4);
        check("to_err_sticky", 32'(merr[1]), 32'd1);
        adv();
        reset_cycle();
        idle();
        eval();
        check("to_err_cleared", 32'(merr[1]), 32'd0);
        adv();

        // Memory never ready on the short-timeout instance.
        idle();
        MemReq = 1;
        for (int i = 0; i < 4; i++) begin eval(); adv(); end
        eval();
        check("to_never_abort", 32'(got_ctrl(1)), 32'h78);
        check("to_never_err", 32'(merr[1]), 32'd1);
        adv();
        eval();
        check("to_restall", 32'(got_ctrl(1)), 32'h00);
        adv();

        // Branch under memory stall is deferred to the release cycle.
        reset_cycle();
        idle();
        MemReq = 1; BranchTaken = 1;
        for (int i = 0; i < 2; i++) begin
            eval();
            check("br_stall_ctrl", 32'(got_ctrl(0)), 32'h00);
            adv();
        end
        MemReady = 1;
        eval();
        check("br_release_ctrl", 32'(got_ctrl(0)), 32'h7F);
        adv();

        // Reset mid-wait: no abort, no error afterwards.
        reset_cycle();
        idle();
        MemReq = 1;
        for (int i = 0; i < 2; i++) begin eval(); adv(); end
        reset_cycle();
        idle();
        for (int i = 0; i < 4; i++) begin
            eval();
            check("rst_wait_ctrl", 32'(got_ctrl(1)), 32'h7C);
            check("rst_wait_err", 32'(merr[1]), 32'd0);
            adv();
        end

        // Forwarding priority and register 0.
        idle();
        MEMRd = 5; WBRd = 5; MEMRegWrite = 1; WBRegWrite = 1; EXRs1 = 5; EXRs2 = 5;
        eval();
        check("fwd_mem", 32'(fa[0]), 32'h2);
        check("fwd_memB", 32'(fb[0]), 32'h2);
        adv();
        MEMRegWrite = 0;
        eval();
        check("fwd_wb", 32'(fa[0]), 32'h1);
        adv();
        MEMRd = 0; WBRd = 0; MEMRegWrite = 1; EXRs1 = 0;
        eval();
        check("fwd_r0", 32'(fa[0]), 32'h0);
        adv();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            eval();
            adv();
        end

        // Saturation of the stall counter.
        reset_cycle();
        idle();
        EXMemRead = 1; EXRd = 3; IDRs1 = 3; IDUsesRs1 = 1;
        do_check = 1'b0;
        for (int i = 0; i < 65540; i++) begin eval(); adv(); end
        do_check = 1'b1;
        eval();
        check("sat_stalls0", 32'(stc[0]), 32'hFFFF);
        check("sat_stalls1", 32'(stc[1]), 32'hFFFF);
        adv();
        reset_cycle();
        idle();
        eval();
        check("sat_cleared", 32'(stc[0]), 32'd0);
        adv();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
